// File: rtl/lc4_wb_arbiter_pkg.sv
// Shared LC4 definitions: register index width, default word width and the
// tag layout of a write-back queue entry.
package lc4_wb_arbiter_pkg;

    localparam int REG_W  = 3;
    localparam int WORD_W = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Queue entry = {valid, rd, data}; the data field is held beside the tag
    // because its width follows the word-width parameter of the instance.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
    } q_tag_t;

    // True when a qualified register index matches another index.
    function automatic logic idx_match(input logic v, input reg_idx_t a, input reg_idx_t b);
        return v && (a == b);
    endfunction

endpackage

// File: rtl/lc4_wb_arbiter_if.sv
// Bus bundle between the pipeline (master) and the write-back arbiter (slave).
interface lc4_wb_arbiter_if
    import lc4_wb_arbiter_pkg::*;
#(
    parameter int n = WORD_W
);
    logic           i_alu_valid;
    reg_idx_t       i_alu_rd;
    logic [n-1:0]   i_alu_data;
    logic           i_ld_valid;
    reg_idx_t       i_ld_rd;
    logic [n-1:0]   i_ld_data;
    logic           o_ld_ready;
    reg_idx_t       o_rd;
    logic [n-1:0]   o_wdata;
    logic           o_rd_we;
    reg_idx_t       i_rs;
    reg_idx_t       i_rt;
    logic [n-1:0]   o_rs_fwd;
    logic [n-1:0]   o_rt_fwd;
    logic           o_rs_hit;
    logic           o_rt_hit;
    logic           o_stall;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_valid, i_ld_rd, i_ld_data,
        output i_rs, i_rt,
        input  o_ld_ready, o_rd, o_wdata, o_rd_we,
        input  o_rs_fwd, o_rt_fwd, o_rs_hit, o_rt_hit, o_stall
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        input  i_rs, i_rt,
        output o_ld_ready, o_rd, o_wdata, o_rd_we,
        output o_rs_fwd, o_rt_fwd, o_rs_hit, o_rt_hit, o_stall
    );
endinterface

// File: rtl/lc4_wb_fifo2.sv
// Two-entry load write queue with in-place squash of matching entries and a
// dependency lookup for the two source selectors of the reading instruction.
module lc4_wb_fifo2
    import lc4_wb_arbiter_pkg::*;
#(
    parameter int n     = WORD_W,
    parameter int DEPTH = 2
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         push,
    input  logic         push_valid,
    input  reg_idx_t     push_rd,
    input  logic [n-1:0] push_data,
    input  logic         pop,
    input  logic         squash,
    input  reg_idx_t     squash_rd,
    input  reg_idx_t     rs,
    input  reg_idx_t     rt,
    output logic         full,
    output logic         empty,
    output logic         head_valid,
    output reg_idx_t     head_rd,
    output logic [n-1:0] head_data,
    output logic         dep_hit
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    q_tag_t             tag_r  [2];
    logic [n-1:0]       data_r [2];
    logic               head_r;
    logic               tail_r;
    logic [CNT_W-1:0]   count_r;

    // Entry storage: a popped slot loses its valid bit so only live entries
    // can squash-match or raise a dependency; the push into the tail wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                tag_r[i]  <= '{valid: 1'b0, rd: 3'd0};
                data_r[i] <= {n{1'b0}};
            end
        end else if (en) begin
            for (int i = 0; i < 2; i++) begin
                if (pop && (head_r == 1'(i))) begin
                    tag_r[i].valid <= 1'b0;
                end else if (idx_match(squash, tag_r[i].rd, squash_rd)) begin
                    tag_r[i].valid <= 1'b0;
                end
                if (push && (tail_r == 1'(i))) begin
                    tag_r[i]  <= '{valid: push_valid, rd: push_rd};
                    data_r[i] <= push_data;
                end
            end
        end
    end

    // Pointers wrap modulo 2; occupancy is unchanged by a paired push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            head_r <= head_r ^ pop;
            tail_r <= tail_r ^ push;
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Status and head view.
    always_comb begin
        full       = (count_r == CNT_W'(DEPTH));
        empty      = (count_r == {CNT_W{1'b0}});
        head_valid = tag_r[head_r].valid;
        head_rd    = tag_r[head_r].rd;
        head_data  = data_r[head_r];
    end

    // A source depends on the queue when any live entry targets it.
    always_comb begin
        dep_hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (idx_match(tag_r[i].valid, tag_r[i].rd, rs) ||
                idx_match(tag_r[i].valid, tag_r[i].rd, rt)) begin
                dep_hit = 1'b1;
            end else begin
                dep_hit = dep_hit;
            end
        end
    end

endmodule

// File: rtl/lc4_wb_arbiter.sv
// Register-file write-back arbiter: ALU results write the next cycle with
// priority, loads are queued and drained in order when the ALU is idle.
module lc4_wb_arbiter
    import lc4_wb_arbiter_pkg::*;
#(
    parameter int n     = WORD_W,
    parameter int DEPTH = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gwe,
    lc4_wb_arbiter_if.slave  bus
);
    logic         q_full_s;
    logic         q_empty_s;
    logic         q_head_valid_s;
    reg_idx_t     q_head_rd_s;
    logic [n-1:0] q_head_data_s;
    logic         q_dep_s;
    logic         ld_ready_s;
    logic         ld_push_s;
    logic         ld_push_valid_s;
    logic         q_pop_s;

    reg_idx_t     rd_r;
    logic [n-1:0] wdata_r;
    logic         we_r;

    // Load acceptance and queue control; a load whose rd equals the same-cycle
    // ALU rd is older than the ALU result and therefore enters already dead.
    always_comb begin
        ld_ready_s      = !q_full_s && gwe;
        ld_push_s       = bus.i_ld_valid && ld_ready_s;
        ld_push_valid_s = !idx_match(bus.i_alu_valid, bus.i_alu_rd, bus.i_ld_rd);
        q_pop_s         = !q_empty_s && !bus.i_alu_valid;
    end

    lc4_wb_fifo2 #(.n(n), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (gwe),
        .push       (ld_push_s),
        .push_valid (ld_push_valid_s),
        .push_rd    (bus.i_ld_rd),
        .push_data  (bus.i_ld_data),
        .pop        (q_pop_s),
        .squash     (bus.i_alu_valid),
        .squash_rd  (bus.i_alu_rd),
        .rs         (bus.i_rs),
        .rt         (bus.i_rt),
        .full       (q_full_s),
        .empty      (q_empty_s),
        .head_valid (q_head_valid_s),
        .head_rd    (q_head_rd_s),
        .head_data  (q_head_data_s),
        .dep_hit    (q_dep_s)
    );

    // Output write port: ALU first, else queue head, else an idle (we=0) cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r    <= 3'd0;
            wdata_r <= {n{1'b0}};
            we_r    <= 1'b0;
        end else if (gwe) begin
            if (bus.i_alu_valid) begin
                rd_r    <= bus.i_alu_rd;
                wdata_r <= bus.i_alu_data;
                we_r    <= 1'b1;
            end else if (!q_empty_s) begin
                rd_r    <= q_head_rd_s;
                wdata_r <= q_head_data_s;
                we_r    <= q_head_valid_s;
            end else begin
                we_r    <= 1'b0;
            end
        end
    end

    // Bypass from the pending register-file write and load-dependency stall.
    always_comb begin
        bus.o_ld_ready = ld_ready_s;
        bus.o_rd       = rd_r;
        bus.o_wdata    = wdata_r;
        bus.o_rd_we    = we_r;
        bus.o_rs_hit   = idx_match(we_r, rd_r, bus.i_rs);
        bus.o_rt_hit   = idx_match(we_r, rd_r, bus.i_rt);
        if (bus.o_rs_hit) bus.o_rs_fwd = wdata_r;
        else              bus.o_rs_fwd = {n{1'b0}};
        if (bus.o_rt_hit) bus.o_rt_fwd = wdata_r;
        else              bus.o_rt_fwd = {n{1'b0}};
        bus.o_stall    = q_dep_s;
    end

endmodule
